// File: rtl/multicycle_ctrl.sv
// Main control FSM for the multi-cycle RV32I core: sequences FETCH/DECODE/EXEC/MEM/WB,
// drives datapath mux selects and strobes, and traps on illegal opcodes or memory timeouts.
module multicycle_ctrl #(
  parameter int unsigned WAIT_LIMIT = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opcode,
  input  logic       branch_cond,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       ir_we,
  output logic       pc_we,
  output logic [1:0] pc_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic       reg_we,
  output logic [1:0] wb_sel,
  output logic       instr_done,
  output logic       trap,
  output logic [2:0] state
);

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_TRAP   = 3'd5;

  localparam logic [3:0] CL_R      = 4'd0;
  localparam logic [3:0] CL_IMM    = 4'd1;
  localparam logic [3:0] CL_LOAD   = 4'd2;
  localparam logic [3:0] CL_STORE  = 4'd3;
  localparam logic [3:0] CL_BRANCH = 4'd4;
  localparam logic [3:0] CL_JAL    = 4'd5;
  localparam logic [3:0] CL_JALR   = 4'd6;
  localparam logic [3:0] CL_LUI    = 4'd7;
  localparam logic [3:0] CL_AUIPC  = 4'd8;
  localparam logic [3:0] CL_ILL    = 4'd15;

  localparam logic [7:0] WAIT_MAX = 8'(WAIT_LIMIT - 32'd1);

  logic [2:0] state_q, state_d;
  logic [3:0] class_q, class_d;
  logic [7:0] wait_q, wait_d;
  logic       trap_q, trap_d;

  logic mem_req_s, mem_we_s, ir_we_s, pc_we_s, reg_we_s, instr_done_s;

  function automatic logic [3:0] classify(input logic [6:0] op);
    logic [3:0] cl;
    case (op)
      7'b0110011: cl = CL_R;
      7'b0010011: cl = CL_IMM;
      7'b0000011: cl = CL_LOAD;
      7'b0100011: cl = CL_STORE;
      7'b1100011: cl = CL_BRANCH;
      7'b1101111: cl = CL_JAL;
      7'b1100111: cl = CL_JALR;
      7'b0110111: cl = CL_LUI;
      7'b0010111: cl = CL_AUIPC;
      default:    cl = CL_ILL;
    endcase
    return cl;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
      class_q <= 4'd0;
      wait_q  <= 8'd0;
      trap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      class_q <= class_d;
      wait_q  <= wait_d;
      trap_q  <= trap_d;
    end
  end

  always_comb begin
    state_d = state_q;
    class_d = class_q;
    case (state_q)
      S_FETCH: begin
        if (mem_ready) begin
          state_d = S_DECODE;
        end else if (wait_q == WAIT_MAX) begin
          state_d = S_TRAP;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_DECODE: begin
        class_d = classify(opcode);
        if (class_d == CL_ILL) begin
          state_d = S_TRAP;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        case (class_q)
          CL_LOAD, CL_STORE:                       state_d = S_MEM;
          CL_BRANCH:                               state_d = S_FETCH;
          CL_R, CL_IMM, CL_JAL, CL_JALR, CL_LUI,
          CL_AUIPC:                                state_d = S_WB;
          default:                                 state_d = S_TRAP;
        endcase
      end
      S_MEM: begin
        if (mem_ready) begin
          if (class_q == CL_LOAD) begin
            state_d = S_WB;
          end else begin
            state_d = S_FETCH;
          end
        end else if (wait_q == WAIT_MAX) begin
          state_d = S_TRAP;
        end else begin
          state_d = S_MEM;
        end
      end
      S_WB:    state_d = S_FETCH;
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_TRAP;
    endcase
  end

  // Wait counter restarts on every state entry and counts unanswered memory cycles.
  always_comb begin
    if (state_d != state_q) begin
      wait_d = 8'd0;
    end else if (((state_q == S_FETCH) || (state_q == S_MEM)) && !mem_ready) begin
      wait_d = wait_q + 8'd1;
    end else begin
      wait_d = wait_q;
    end
    if (state_d == S_TRAP) begin
      trap_d = 1'b1;
    end else begin
      trap_d = trap_q;
    end
  end

  always_comb begin
    mem_req_s    = 1'b0;
    mem_we_s     = 1'b0;
    ir_we_s      = 1'b0;
    pc_we_s      = 1'b0;
    reg_we_s     = 1'b0;
    instr_done_s = 1'b0;
    pc_src       = 2'b00;
    alu_src_a    = 2'b00;
    alu_src_b    = 2'b00;
    alu_op       = 2'b00;
    wb_sel       = 2'b00;
    case (state_q)
      S_FETCH: begin
        mem_req_s = 1'b1;
        ir_we_s   = mem_ready;
      end
      S_DECODE: begin
        mem_req_s = 1'b0;
      end
      S_EXEC: begin
        case (class_q)
          CL_R: begin
            alu_op = 2'b10;
          end
          CL_IMM: begin
            alu_src_b = 2'b01;
            alu_op    = 2'b10;
          end
          CL_LOAD, CL_STORE, CL_JALR: begin
            alu_src_b = 2'b01;
          end
          CL_BRANCH: begin
            alu_op       = 2'b01;
            pc_we_s      = 1'b1;
            instr_done_s = 1'b1;
            pc_src       = branch_cond ? 2'b01 : 2'b00;
          end
          CL_AUIPC: begin
            alu_src_a = 2'b01;
            alu_src_b = 2'b01;
          end
          CL_JAL, CL_LUI: begin
            alu_src_a = 2'b10;
            alu_src_b = 2'b10;
          end
          default: begin
            alu_op = 2'b00;
          end
        endcase
      end
      S_MEM: begin
        mem_req_s = 1'b1;
        mem_we_s  = (class_q == CL_STORE);
        if (mem_ready && (class_q == CL_STORE)) begin
          pc_we_s      = 1'b1;
          instr_done_s = 1'b1;
        end else begin
          pc_we_s      = 1'b0;
          instr_done_s = 1'b0;
        end
      end
      S_WB: begin
        reg_we_s     = 1'b1;
        pc_we_s      = 1'b1;
        instr_done_s = 1'b1;
        case (class_q)
          CL_LOAD:  wb_sel = 2'b01;
          CL_JAL:   begin wb_sel = 2'b10; pc_src = 2'b01; end
          CL_JALR:  begin wb_sel = 2'b10; pc_src = 2'b10; end
          CL_LUI:   wb_sel = 2'b11;
          default:  wb_sel = 2'b00;
        endcase
      end
      default: begin
        mem_req_s = 1'b0;
      end
    endcase
  end

  // Reset masks every strobe combinationally so an in-flight instruction never retires.
  assign mem_req    = mem_req_s    & ~rst;
  assign mem_we     = mem_we_s     & ~rst;
  assign ir_we      = ir_we_s      & ~rst;
  assign pc_we      = pc_we_s      & ~rst;
  assign reg_we     = reg_we_s     & ~rst;
  assign instr_done = instr_done_s & ~rst;
  assign trap       = trap_q;
  assign state      = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed, table-driven bench for multicycle_ctrl (WAIT_LIMIT=4); each row is one clock cycle.
module tb_multicycle_ctrl;

  typedef struct packed {
    logic [2:0] st;
    logic       mreq;
    logic       mwe;
    logic       irwe;
    logic       pcwe;
    logic [1:0] pcsrc;
    logic [1:0] a;
    logic [1:0] b;
    logic [1:0] op;
    logic       rwe;
    logic [1:0] wbs;
    logic       done;
    logic       trap;
  } out_t;

  typedef struct {
    logic       rst;
    logic [6:0] opc;
    logic       bc;
    logic       rdy;
    out_t       exp;
    out_t       mask;
  } vec_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_BAD    = 7'b1111111;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] opcode = 7'd0;
  logic       branch_cond = 1'b0;
  logic       mem_ready = 1'b0;
  logic       mem_req, mem_we, ir_we, pc_we, reg_we, instr_done, trap;
  logic [1:0] pc_src, alu_src_a, alu_src_b, alu_op, wb_sel;
  logic [2:0] state;

  int checks = 0;
  int errors = 0;
  vec_t vecs[$];
  out_t m_all;
  out_t m_rst;

  multicycle_ctrl #(.WAIT_LIMIT(4)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .branch_cond(branch_cond), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .ir_we(ir_we), .pc_we(pc_we), .pc_src(pc_src),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op), .reg_we(reg_we),
    .wb_sel(wb_sel), .instr_done(instr_done), .trap(trap), .state(state)
  );

  always #5 clk = ~clk;

  function automatic out_t o_fetch(input logic rdy);
    out_t o = '0;
    o.st = 3'd0; o.mreq = 1'b1; o.irwe = rdy;
    return o;
  endfunction

  function automatic out_t o_dec();
    out_t o = '0;
    o.st = 3'd1;
    return o;
  endfunction

  function automatic out_t o_exec(input logic [1:0] a, input logic [1:0] b, input logic [1:0] op,
                                  input logic pcwe, input logic [1:0] pcsrc);
    out_t o = '0;
    o.st = 3'd2; o.a = a; o.b = b; o.op = op;
    o.pcwe = pcwe; o.done = pcwe; o.pcsrc = pcsrc;
    return o;
  endfunction

  function automatic out_t o_mem(input logic we, input logic fin);
    out_t o = '0;
    o.st = 3'd3; o.mreq = 1'b1; o.mwe = we; o.pcwe = fin; o.done = fin;
    return o;
  endfunction

  function automatic out_t o_wb(input logic [1:0] wbs, input logic [1:0] pcsrc);
    out_t o = '0;
    o.st = 3'd4; o.rwe = 1'b1; o.wbs = wbs; o.pcwe = 1'b1; o.pcsrc = pcsrc; o.done = 1'b1;
    return o;
  endfunction

  function automatic out_t o_st(input logic [2:0] st, input logic tr);
    out_t o = '0;
    o.st = st; o.trap = tr;
    return o;
  endfunction

  task automatic add(input logic r, input logic [6:0] opc, input logic bc, input logic rdy,
                     input out_t exp, input out_t mask);
    vec_t v;
    v.rst = r; v.opc = opc; v.bc = bc; v.rdy = rdy; v.exp = exp; v.mask = mask;
    vecs.push_back(v);
  endtask

  task automatic step(input logic r, input logic [6:0] opc, input logic bc, input logic rdy,
                      input out_t exp, input out_t mask, input string name);
    out_t act;
    @(negedge clk);
    rst = r; opcode = opc; branch_cond = bc; mem_ready = rdy;
    #2;
    act = {state, mem_req, mem_we, ir_we, pc_we, pc_src, alu_src_a, alu_src_b, alu_op,
           reg_we, wb_sel, instr_done, trap};
    checks++;
    if ((act & mask) !== (exp & mask)) begin
      errors++;
      $display("FAIL %s: got %b required %b (mask %b)", name, act, exp, mask);
    end
  endtask

  initial begin
    m_all = '1;
    m_rst = '0;
    m_rst.st = 3'b111; m_rst.mreq = 1'b1; m_rst.mwe = 1'b1; m_rst.irwe = 1'b1;
    m_rst.pcwe = 1'b1; m_rst.rwe = 1'b1; m_rst.done = 1'b1;

    // Reset held two cycles; the first row only checks the forced-low strobes.
    add(1'b1, OP_R, 1'b0, 1'b1, o_st(3'd0, 1'b0), m_rst & ~out_t'({3'b111, 17'd0}));
    add(1'b1, OP_R, 1'b0, 1'b1, o_st(3'd0, 1'b0), m_all);
    // R, zero-wait
    add(1'b0, OP_R, 1'b0, 1'b1, o_fetch(1'b1), m_all);
    add(1'b0, OP_R, 1'b0, 1'b1, o_dec(), m_all);
    add(1'b0, OP_R, 1'b0, 1'b1, o_exec(2'b00, 2'b00, 2'b10, 1'b0, 2'b00), m_all);
    add(1'b0, OP_R, 1'b0, 1'b1, o_wb(2'b00, 2'b00), m_all);
    // IMM
    add(1'b0, OP_IMM, 1'b0, 1'b1, o_fetch(1'b1), m_all);
    add(1'b0, OP_IMM, 1'b0, 1'b1, o_dec(), m_all);
    add(1'b0, OP_IMM, 1'b0, 1'b1, o_exec(2'b00, 2'b01, 2'b10, 1'b0, 2'b00), m_all);
    add(1'b0, OP_IMM, 1'b0, 1'b1, o_wb(2'b00, 2'b00), m_all);
    // JAL
    add(1'b0, OP_JAL, 1'b0, 1'b1, o_fetch(1'b1), m_all);
    add(1'b0, OP_JAL, 1'b0, 1'b1, o_dec(), m_all);
    add(1'b0, OP_JAL, 1'b0, 1'b1, o_exec(2'b10, 2'b10, 2'b00, 1'b0, 2'b00), m_all);
    add(1'b0, OP_JAL, 1'b0, 1'b1, o_wb(2'b10, 2'b01), m_all);
    // JALR
    add(1'b0, OP_JALR, 1'b0, 1'b1, o_fetch(1'b1), m_all);
    add(1'b0, OP_JALR, 1'b0, 1'b1, o_dec(), m_all);
    add(1'b0, OP_JALR, 1'b0, 1'b1, o_exec(2'b00, 2'b01, 2'b00, 1'b0, 2'b00), m_all);
    add(1'b0, OP_JALR, 1'b0, 1'b1, o_wb(2'b10, 2'b10), m_all);
    // LUI
    add(1'b0, OP_LUI, 1'b0, 1'b1, o_fetch(1'b1), m_all);
    add(1'b0, OP_LUI, 1'b0, 1'b1, o_dec(), m_all);
    add(1'b0, OP_LUI, 1'b0, 1'b1, o_exec(2'b10, 2'b10, 2'b00, 1'b0, 2'b00), m_all);
    add(1'b0, OP_LUI, 1'b0, 1'b1, o_wb(2'b11, 2'b00), m_all);
    // AUIPC
    add(1'b0, OP_AUIPC, 1'b0, 1'b1, o_fetch(1'b1), m_all);
    add(1'b0, OP_AUIPC, 1'b0, 1'b1, o_dec(), m_all);
    add(1'b0, OP_AUIPC, 1'b0, 1'b1, o_exec(2'b01, 2'b01, 2'b00, 1'b0, 2'b00), m_all);
    add(1'b0, OP_AUIPC, 1'b0, 1'b1, o_wb(2'b00, 2'b00), m_all);
    // STORE, zero-wait: retires from MEM
    add(1'b0, OP_STORE, 1'b0, 1'b1, o_fetch(1'b1), m_all);
    add(1'b0, OP_STORE, 1'b0, 1'b1, o_dec(), m_all);
    add(1'b0, OP_STORE, 1'b0, 1'b1, o_exec(2'b00, 2'b01, 2'b00, 1'b0, 2'b00), m_all);
    add(1'b0, OP_STORE, 1'b0, 1'b1, o_mem(1'b1, 1'b1), m_all);
    // LOAD with three MEM wait cycles: 8 cycles total
    add(1'b0, OP_LOAD, 1'b0, 1'b1, o_fetch(1'b1), m_all);
    add(1'b0, OP_LOAD, 1'b0, 1'b1, o_dec(), m_all);
    add(1'b0, OP_LOAD, 1'b0, 1'b0, o_exec(2'b00, 2'b01, 2'b00, 1'b0, 2'b00), m_all);
    for (int i = 0; i < 3; i++) add(1'b0, OP_LOAD, 1'b0, 1'b0, o_mem(1'b0, 1'b0), m_all);
    add(1'b0, OP_LOAD, 1'b0, 1'b1, o_mem(1'b0, 1'b0), m_all);
    add(1'b0, OP_LOAD, 1'b0, 1'b1, o_wb(2'b01, 2'b00), m_all);
    // BRANCH taken, then not taken
    add(1'b0, OP_BRANCH, 1'b1, 1'b1, o_fetch(1'b1), m_all);
    add(1'b0, OP_BRANCH, 1'b1, 1'b1, o_dec(), m_all);
    add(1'b0, OP_BRANCH, 1'b1, 1'b1, o_exec(2'b00, 2'b00, 2'b01, 1'b1, 2'b01), m_all);
    add(1'b0, OP_BRANCH, 1'b0, 1'b1, o_fetch(1'b1), m_all);
    add(1'b0, OP_BRANCH, 1'b0, 1'b1, o_dec(), m_all);
    add(1'b0, OP_BRANCH, 1'b0, 1'b1, o_exec(2'b00, 2'b00, 2'b01, 1'b1, 2'b00), m_all);
    // Reset during MEM of a STORE: nothing retires, mem_we low in the reset cycle
    add(1'b0, OP_STORE, 1'b0, 1'b1, o_fetch(1'b1), m_all);
    add(1'b0, OP_STORE, 1'b0, 1'b1, o_dec(), m_all);
    add(1'b0, OP_STORE, 1'b0, 1'b0, o_exec(2'b00, 2'b01, 2'b00, 1'b0, 2'b00), m_all);
    add(1'b0, OP_STORE, 1'b0, 1'b0, o_mem(1'b1, 1'b0), m_all);
    add(1'b1, OP_STORE, 1'b0, 1'b1, o_st(3'd3, 1'b0), m_all);
    add(1'b0, OP_R, 1'b0, 1'b1, o_fetch(1'b1), m_all);

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].rst, vecs[i].opc, vecs[i].bc, vecs[i].rdy, vecs[i].exp, vecs[i].mask,
           $sformatf("row%0d", i));
    end

    // Illegal opcode: DECODE -> TRAP, held for 20 cycles regardless of memory activity.
    step(1'b0, OP_BAD, 1'b0, 1'b1, o_dec(), m_all, "illegal_decode");
    for (int i = 0; i < 20; i++)
      step(1'b0, OP_R, 1'b0, i[0], o_st(3'd5, 1'b1), m_all, $sformatf("trap_hold%0d", i));
    step(1'b1, OP_R, 1'b0, 1'b0, o_st(3'd5, 1'b1), m_rst, "trap_rst");

    // Unanswered fetch: exactly WAIT_LIMIT cycles of mem_req, then TRAP.
    for (int i = 0; i < 4; i++)
      step(1'b0, OP_R, 1'b0, 1'b0, o_fetch(1'b0), m_all, $sformatf("wait_fetch%0d", i));
    step(1'b0, OP_R, 1'b0, 1'b0, o_st(3'd5, 1'b1), m_all, "wait_trap");
    step(1'b0, OP_R, 1'b0, 1'b1, o_st(3'd5, 1'b1), m_all, "wait_trap_sticky");
    step(1'b1, OP_R, 1'b0, 1'b0, o_st(3'd5, 1'b1), m_rst, "wait_rst");

    // Ready on the last allowed cycle wins over the timeout.
    for (int i = 0; i < 3; i++)
      step(1'b0, OP_R, 1'b0, 1'b0, o_fetch(1'b0), m_all, $sformatf("edge_fetch%0d", i));
    step(1'b0, OP_R, 1'b0, 1'b1, o_fetch(1'b1), m_all, "edge_fetch_ready");
    step(1'b0, OP_R, 1'b0, 1'b1, o_dec(), m_all, "edge_decode");
    step(1'b0, OP_R, 1'b0, 1'b1, o_exec(2'b00, 2'b00, 2'b10, 1'b0, 2'b00), m_all, "edge_exec");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
